// File: rtl/cv32e40p_alu_tmr_retry_ctrl.sv
// rtl/cv32e40p_alu_tmr_retry_ctrl.sv - replay sequencer for the triplicated EX-stage ALU
// Define ALU_TMR_FAULT_LOG_EN to add per-source fault counters on src_cnt_o.
module cv32e40p_alu_tmr_retry_ctrl #(
   parameter int MAX_RETRY = 2,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_i,
   input  logic               alu_ready_i,
   input  logic [2:0]         fault_vec_i,
   input  logic               flush_i,
   input  logic               clear_i,
   output logic               alu_enable_o,
   output logic               stall_o,
   output logic               replay_o,
   output logic               fatal_o,
   output logic               err_o,
   output logic [CNT_W-1:0]   fault_cnt_o,
   output logic [2:0]         last_fault_o,
   output logic [3*CNT_W-1:0] src_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_REPLAY, S_WAIT} state_t;

   state_t     state_q, state_d;
   logic [2:0] attempt_q, attempt_d;
   logic       cmp, faulty, fatal_set;

   // Clear is applied before the increment so a same-cycle fault reads back as 1.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                             input logic clr, input logic inc);
      logic [CNT_W-1:0] b;
      b = clr ? '0 : v;
      if (inc && (b != '1))
         b = b + CNT_W'(1);
      return b;
   endfunction

   assign cmp          = alu_ready_i && ((state_q == S_IDLE) ? valid_i : (state_q == S_WAIT));
   assign faulty       = cmp && (|fault_vec_i);
   assign alu_enable_o = ((state_q == S_IDLE) && valid_i) || (state_q == S_REPLAY);

   always_comb begin
      state_d   = state_q;
      attempt_d = attempt_q;
      stall_o   = 1'b0;
      fatal_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (faulty) begin
               stall_o   = 1'b1;
               attempt_d = 3'd1;
               state_d   = S_REPLAY;
            end
         end
         S_REPLAY: begin
            if (flush_i) begin
               attempt_d = 3'd0;
               state_d   = S_IDLE;
            end else begin
               stall_o = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               attempt_d = 3'd0;
               state_d   = S_IDLE;
            end else if (!cmp) begin
               stall_o = 1'b1;
            end else if (!faulty) begin
               attempt_d = 3'd0;
               state_d   = S_IDLE;
            end else if (attempt_q < 3'(MAX_RETRY)) begin
               stall_o   = 1'b1;
               attempt_d = attempt_q + 3'd1;
               state_d   = S_REPLAY;
            end else begin
               // Out of retries: the voted result is accepted and the pipe released.
               fatal_set = 1'b1;
               attempt_d = 3'd0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            attempt_d = 3'd0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         attempt_q    <= 3'd0;
         replay_o     <= 1'b0;
         fatal_o      <= 1'b0;
         err_o        <= 1'b0;
         fault_cnt_o  <= '0;
         last_fault_o <= 3'd0;
      end else begin
         state_q     <= state_d;
         attempt_q   <= attempt_d;
         replay_o    <= (state_d == S_REPLAY);
         fatal_o     <= fatal_set;
         err_o       <= clear_i ? 1'b0 : (err_o | fatal_set);
         fault_cnt_o <= bump(fault_cnt_o, clear_i, faulty);
         if (faulty)
            last_fault_o <= fault_vec_i;
      end
   end

`ifdef ALU_TMR_FAULT_LOG_EN
   logic [CNT_W-1:0] src_q [3];

   for (genvar k = 0; k < 3; k++) begin : g_src
      always_ff @(posedge clk) begin
         if (!rst_n)
            src_q[k] <= '0;
         else
            src_q[k] <= bump(src_q[k], clear_i, faulty && fault_vec_i[k]);
      end
   end

   assign src_cnt_o = {src_q[2], src_q[1], src_q[0]};
`else
   assign src_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_alu_tmr_retry_ctrl.sv
// tb/tb_cv32e40p_alu_tmr_retry_ctrl.sv - directed checks for the TMR ALU retry sequencer
module tb_cv32e40p_alu_tmr_retry_ctrl;

   localparam int CNT_W = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               valid_i, alu_ready_i, flush_i, clear_i;
   logic [2:0]         fault_vec_i;
   logic               alu_enable_o, stall_o, replay_o, fatal_o, err_o;
   logic [CNT_W-1:0]   fault_cnt_o;
   logic [2:0]         last_fault_o;
   logic [3*CNT_W-1:0] src_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e40p_alu_tmr_retry_ctrl #(.MAX_RETRY(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_ready_i(alu_ready_i),
      .fault_vec_i(fault_vec_i), .flush_i(flush_i), .clear_i(clear_i),
      .alu_enable_o(alu_enable_o), .stall_o(stall_o), .replay_o(replay_o),
      .fatal_o(fatal_o), .err_o(err_o), .fault_cnt_o(fault_cnt_o),
      .last_fault_o(last_fault_o), .src_cnt_o(src_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, then apply new inputs and let them settle.
   task automatic step(input logic v, input logic r, input logic [2:0] f,
                       input logic fl, input logic cl);
      @(posedge clk);
      #1;
      valid_i = v; alu_ready_i = r; fault_vec_i = f; flush_i = fl; clear_i = cl;
      #2;
   endtask

   function automatic logic [3*CNT_W-1:0] src_exp(input int b2, input int b1, input int b0);
`ifdef ALU_TMR_FAULT_LOG_EN
      return {4'(b2), 4'(b1), 4'(b0)};
`else
      return '0;
`endif
   endfunction

   initial begin
      rst_n = 1'b0;
      valid_i = 0; alu_ready_i = 0; fault_vec_i = 3'b000; flush_i = 0; clear_i = 0;
      step(0, 0, 3'b000, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_enable", alu_enable_o, 0);
      chk("rst_regs", {replay_o, fatal_o, err_o, last_fault_o}, 0);
      chk("rst_cnt", fault_cnt_o, 0);
      chk("rst_src", src_cnt_o, 0);
      rst_n = 1'b1;

      // T1 clean op
      step(1, 1, 3'b000, 0, 0);
      chk("t1_stall", stall_o, 0);
      chk("t1_enable", alu_enable_o, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t1_replay", replay_o, 0);
      chk("t1_cnt", fault_cnt_o, 0);

      // T2 single upset, replay completes clean one cycle into WAIT
      step(1, 1, 3'b001, 0, 0);
      chk("t2_stall_issue", stall_o, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t2_replay", replay_o, 1);
      chk("t2_stall_replay", stall_o, 1);
      chk("t2_enable_replay", alu_enable_o, 1);
      chk("t2_cnt", fault_cnt_o, 1);
      chk("t2_last", last_fault_o, 3'b001);
      step(0, 0, 3'b000, 0, 0);
      chk("t2_replay_off", replay_o, 0);
      chk("t2_stall_wait", stall_o, 1);
      chk("t2_enable_wait", alu_enable_o, 0);
      step(0, 1, 3'b000, 0, 0);
      chk("t2_stall_done", stall_o, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("t2_err", {err_o, fatal_o}, 0);
      chk("t2_src", src_cnt_o, src_exp(0, 0, 1));

      // T3 persistent fault until retries exhausted
      step(1, 1, 3'b010, 0, 0);
      chk("t3_stall_issue", stall_o, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t3_replay1", replay_o, 1);
      step(0, 1, 3'b010, 0, 0);
      chk("t3_stall_c2", stall_o, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t3_replay2", replay_o, 1);
      chk("t3_cnt_mid", fault_cnt_o, 3);
      step(0, 1, 3'b010, 0, 0);
      chk("t3_stall_c3", stall_o, 0);
      chk("t3_fatal_early", fatal_o, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("t3_fatal", fatal_o, 1);
      chk("t3_err", err_o, 1);
      chk("t3_cnt", fault_cnt_o, 4);
      chk("t3_replay_off", replay_o, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("t3_fatal_pulse", fatal_o, 0);
      chk("t3_err_sticky", err_o, 1);

      // T5 saturation: 17 faulty completions, each killed in REPLAY
      for (int i = 0; i < 17; i++) begin
         step(1, 1, 3'b101, 0, 0);
         step(0, 0, 3'b000, 1, 0);
      end
      step(0, 0, 3'b000, 0, 0);
      chk("t5_sat", fault_cnt_o, 15);
      chk("t5_err_kept", err_o, 1);
      chk("t5_src_sat", src_cnt_o, src_exp(15, 3, 15));
      step(1, 1, 3'b001, 0, 1);
      step(0, 0, 3'b000, 1, 0);
      chk("t5_clear_inc", fault_cnt_o, 1);
      chk("t5_clear_err", err_o, 0);
      chk("t5_clear_last", last_fault_o, 3'b001);
      chk("t5_clear_src", src_cnt_o, src_exp(0, 0, 1));
      step(0, 0, 3'b000, 0, 0);
      chk("t5_flush_idle", stall_o, 0);

      // T4 flush in WAIT while a multi-cycle replay is outstanding
      step(1, 1, 3'b010, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("t4_replay", replay_o, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t4_stall_w1", stall_o, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t4_stall_w2", stall_o, 1);
      step(0, 0, 3'b000, 1, 0);
      chk("t4_stall_flush", stall_o, 0);
      step(0, 1, 3'b010, 0, 0);
      chk("t4_idle_ready", stall_o, 0);
      chk("t4_no_replay", replay_o, 0);
      chk("t4_no_fatal", fatal_o, 0);
      chk("t4_cnt", fault_cnt_o, 2);
      step(0, 0, 3'b000, 0, 0);
      chk("t4_no_fatal2", {fatal_o, err_o}, 0);
      chk("t4_src", src_cnt_o, src_exp(0, 1, 1));

      // T6 per-source counters after a standalone clear
      step(0, 0, 3'b000, 0, 1);
      step(0, 0, 3'b000, 0, 0);
      chk("t6_clear_cnt", fault_cnt_o, 0);
      chk("t6_clear_src", src_cnt_o, 0);
      step(1, 1, 3'b001, 0, 0);
      step(0, 0, 3'b000, 1, 0);
      step(1, 1, 3'b100, 0, 0);
      step(0, 0, 3'b000, 1, 0);
      step(1, 1, 3'b101, 0, 0);
      step(0, 0, 3'b000, 1, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("t6_src", src_cnt_o, src_exp(2, 0, 2));
      chk("t6_cnt", fault_cnt_o, 3);
      chk("t6_last", last_fault_o, 3'b101);

      // Reset while in REPLAY
      step(1, 1, 3'b011, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("rr_replay", replay_o, 1);
      rst_n = 1'b0;
      step(0, 0, 3'b000, 0, 0);
      rst_n = 1'b1;
      chk("rr_stall", stall_o, 0);
      chk("rr_enable", alu_enable_o, 0);
      chk("rr_regs", {replay_o, fatal_o, err_o, last_fault_o}, 0);
      chk("rr_cnt", fault_cnt_o, 0);
      step(0, 0, 3'b000, 0, 0);
      chk("rr_idle", {stall_o, replay_o}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
